store_buffer: RTL and testbench
===============================

# store_buffer

Write buffer between the write-back stage and the data memory port. It accepts one store per cycle from write-back, holding the physical address, data and size, and drains the stores in order to memory over a req/ack handshake. It asserts `full` so write-back stalls, and reports load/store address overlap so the memory stage can hold a load until an older buffered store has drained.

## Interface
Parameters:
- `DEPTH`, 4: entry count; power of two, ≥2.
- `PA_W`, 15: physical address width.
- `DATA_W`, 32: store data width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enq_v`  in  1  write-back presents a store this cycle.
- `enq_pa`  in  PA_W  store byte address.
- `enq_data`  in  DATA_W  store data, right-justified.
- `enq_size`  in  2  byte count: 00=4, 01=1, 10=2, 11=3.
- `full`  out  1  count==DEPTH; write-back must stall and hold its store.
- `empty`  out  1  count==0.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `mem_req`  out  1  head entry valid, presented to memory.
- `mem_pa`  out  PA_W  head address.
- `mem_data`  out  DATA_W  head data.
- `mem_size`  out  2  head size, same encoding.
- `mem_ack`  in  1  memory accepted the head this cycle.
- `ld_v`  in  1  load lookup valid.
- `ld_pa`  in  PA_W  load start address.
- `ld_size`  in  2  load byte count, same encoding.
- `ld_hit`  out  1  load overlaps at least one valid entry (combinational).

## Operation
- The circular FIFO holds valid bits, PA, data and size per entry. It uses head and tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH, plus a separate count register.
- Enqueue occurs when `enq_v & ~full`. The entry is written at the tail, then the tail and count are updated.
- `enq_v & full` is ignored; no state changes. Upstream guarantees it holds the store.
- Dequeue occurs when `mem_req & mem_ack`. The head entry is invalidated, then the head and count are updated.
- `mem_ack` without `mem_req` is ignored.
- With simultaneous enqueue and dequeue, count is unchanged and both pointers advance. When full, no enqueue occurs even if a dequeue happens in the same cycle, because `full` is registered state.
- `mem_req` = ~empty. The mem_* payload always equals the head entry and is stable while `mem_req` is high and `mem_ack` is low.
- Overlap check:
  - Each range spans start word to end word. Start word = pa[PA_W-1:2]. End word = (pa + bytes − 1)[PA_W-1:2], computed modulo 2^PA_W.
  - `ld_hit` = ld_v & OR over valid entries of (any of the four start/end word pairs equal). This test is conservative at word granularity.
  - An entry dequeued in the current cycle still counts toward the hit.
- Reset sets all valid bits to 0, head, tail and count to 0, and drops any in-flight request. Memory must not complete a request after reset.

## Timing
- Reset values: `full`=0, `empty`=1, `count`=0, `mem_req`=0, `ld_hit`=0, `mem_pa`/`mem_data`/`mem_size`=0.
- Latency: a store enqueued into an empty buffer in cycle N raises `mem_req` in cycle N+1 with its payload.
- Throughput: with `mem_ack` held high, one store drains per cycle.
- `full` and `empty` are decoded from registered count only, with no combinational path from `mem_ack`.
- `ld_hit` is combinational from `ld_*` and the registered entries. Same-cycle enqueues are not visible until N+1.
- No state machine beyond pointer/count state. Buffer states are EMPTY (count 0), PARTIAL, and FULL (count DEPTH), all derived from count.

## Structure
- Package `sb_pkg`: size encodings SZ4=2'b00, SZ1=2'b01, SZ2=2'b10, SZ3=2'b11; `PA_W`, `DATA_W` defaults; function `size_bytes(size)` → 3-bit byte count.
- Sub-module `sb_overlap` takes (a_pa, a_size, b_pa, b_size) and outputs match. It computes start/end words and performs the four comparisons. It is instantiated once per entry; its outputs are ANDed with the entry's valid bit and ORed together.

## Test plan
- Reset, then enqueue PA=0x0010/data=0xDEADBEEF/size=00 in cycle 1 → cycle 2: `mem_req`=1, `mem_pa`=0x0010, `mem_data`=0xDEADBEEF, `mem_size`=00, `count`=1; `mem_ack` in cycle 3 → cycle 4 `empty`=1.
- Five back-to-back enqueues with `mem_ack`=0 (DEPTH=4) → `full`=1 after the fourth; the fifth store (0x0050) is dropped and `count`=4. Then ack four times → drain order 0x0010, 0x0020, 0x0030, 0x0040.
- Full buffer with `enq_v`=1 and `mem_ack`=1 in the same cycle → count goes to 3 and the store is not taken. Next cycle `enq_v`=1 → count returns to 4 and the tail wraps to entry 0.
- Entry PA=0x0006 size=11 (covers bytes 6..8) with ld_pa=0x0008 size=01 → `ld_hit`=1. ld_pa=0x000C → `ld_hit`=0.
- `rst` pulse asserted mid-cycle while count=3 and `mem_req`=1 → outputs immediately go to reset values, before the next clock edge; `mem_ack` afterwards has no effect.
- Steady stream with `mem_ack` tied high → count stays ≤1 and one store completes per cycle.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared definitions for the store buffer.
// Holds the size encodings, default widths and the byte-count helper.
package sb_pkg;

   localparam int PA_W_DEF   = 15;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      SZ4 = 2'b00,
      SZ1 = 2'b01,
      SZ2 = 2'b10,
      SZ3 = 2'b11
   } sb_size_e;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      logic [2:0] n;
      case (size)
         SZ4:     n = 3'd4;
         SZ1:     n = 3'd1;
         SZ2:     n = 3'd2;
         default: n = 3'd3;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/sb_overlap.sv
// Word-granular overlap test between two byte ranges.
// Each range spans at most two adjacent words, so endpoint equality suffices.
module sb_overlap
   import sb_pkg::*;
#(
   parameter int PA_W = PA_W_DEF
) (
   input  logic [PA_W-1:0] a_pa,
   input  logic [1:0]      a_size,
   input  logic [PA_W-1:0] b_pa,
   input  logic [1:0]      b_size,
   output logic            match
);

   localparam int WD_W = PA_W - 2;

   logic [PA_W-1:0] a_last;
   logic [PA_W-1:0] b_last;
   logic [WD_W-1:0] a_sw;
   logic [WD_W-1:0] a_ew;
   logic [WD_W-1:0] b_sw;
   logic [WD_W-1:0] b_ew;

   // last byte address wraps modulo 2^PA_W
   assign a_last = a_pa + PA_W'(size_bytes(a_size)) - PA_W'(1);
   assign b_last = b_pa + PA_W'(size_bytes(b_size)) - PA_W'(1);

   assign a_sw = a_pa[PA_W-1:2];
   assign a_ew = a_last[PA_W-1:2];
   assign b_sw = b_pa[PA_W-1:2];
   assign b_ew = b_last[PA_W-1:2];

   assign match = (a_sw == b_sw) | (a_sw == b_ew) |
                  (a_ew == b_sw) | (a_ew == b_ew);

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between write-back and the data memory port.
// Drains over req/ack and flags loads that overlap a buffered store.
module store_buffer
   import sb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int PA_W   = PA_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enq_v,
   input  logic [PA_W-1:0]   enq_pa,
   input  logic [DATA_W-1:0] enq_data,
   input  logic [1:0]        enq_size,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count,
   output logic              mem_req,
   output logic [PA_W-1:0]   mem_pa,
   output logic [DATA_W-1:0] mem_data,
   output logic [1:0]        mem_size,
   input  logic              mem_ack,
   input  logic              ld_v,
   input  logic [PA_W-1:0]   ld_pa,
   input  logic [1:0]        ld_size,
   output logic              ld_hit
);

   logic [DEPTH-1:0]  valid;
   logic [PA_W-1:0]   pa_q   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [1:0]        size_q [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count_q;
   logic [DEPTH-1:0]  match;
   logic              enq;
   logic              deq;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   assign enq = enq_v & ~full;
   assign deq = mem_req & mem_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid   <= '0;
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pa_q[i]   <= '0;
            data_q[i] <= '0;
            size_q[i] <= '0;
         end
      end else begin
         if (deq) begin
            valid[head] <= 1'b0;
            head        <= head + PTR_W'(1);
         end
         if (enq) begin
            valid[tail]  <= 1'b1;
            pa_q[tail]   <= enq_pa;
            data_q[tail] <= enq_data;
            size_q[tail] <= enq_size;
            tail         <= tail + PTR_W'(1);
         end
         // full blocks enq and empty blocks deq, so head and tail never collide
         case ({enq, deq})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign mem_req  = ~empty;
   assign mem_pa   = pa_q[head];
   assign mem_data = data_q[head];
   assign mem_size = size_q[head];

   for (genvar g = 0; g < DEPTH; g++) begin : g_ov
      sb_overlap #(
         .PA_W (PA_W)
      ) u_ov (
         .a_pa   (pa_q[g]),
         .a_size (size_q[g]),
         .b_pa   (ld_pa),
         .b_size (ld_size),
         .match  (match[g])
      );
   end

   // an entry leaving this cycle is still valid here, so it still blocks
   assign ld_hit = ld_v & |(match & valid);

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based model.
// Overlap is modelled byte by byte at word granularity.
module tb_store_buffer;

   localparam int DEPTH  = 4;
   localparam int PA_W   = 15;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              enq_v;
   logic [PA_W-1:0]   enq_pa;
   logic [DATA_W-1:0] enq_data;
   logic [1:0]        enq_size;
   logic              full;
   logic              empty;
   logic [CNT_W-1:0]  count;
   logic              mem_req;
   logic [PA_W-1:0]   mem_pa;
   logic [DATA_W-1:0] mem_data;
   logic [1:0]        mem_size;
   logic              mem_ack;
   logic              ld_v;
   logic [PA_W-1:0]   ld_pa;
   logic [1:0]        ld_size;
   logic              ld_hit;

   typedef struct {
      logic [PA_W-1:0]   pa;
      logic [DATA_W-1:0] data;
      logic [1:0]        size;
   } st_t;

   st_t q[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   store_buffer #(
      .DEPTH  (DEPTH),
      .PA_W   (PA_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enq_v    (enq_v),
      .enq_pa   (enq_pa),
      .enq_data (enq_data),
      .enq_size (enq_size),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .mem_req  (mem_req),
      .mem_pa   (mem_pa),
      .mem_data (mem_data),
      .mem_size (mem_size),
      .mem_ack  (mem_ack),
      .ld_v     (ld_v),
      .ld_pa    (ld_pa),
      .ld_size  (ld_size),
      .ld_hit   (ld_hit)
   );

   always #5 clk = ~clk;

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 4 : int'(sz);
   endfunction

   function automatic bit ranges_touch(input int apa, input int asz,
                                       input int bpa, input int bsz);
      int m;
      m = 1 << PA_W;
      for (int i = 0; i < asz; i++)
         for (int j = 0; j < bsz; j++)
            if ((((apa + i) % m) >> 2) == (((bpa + j) % m) >> 2))
               return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit model_hit();
      if (!ld_v) return 1'b0;
      foreach (q[k])
         if (ranges_touch(int'(q[k].pa), nbytes(q[k].size),
                          int'(ld_pa), nbytes(ld_size)))
            return 1'b1;
      return 1'b0;
   endfunction

   // drives one cycle and advances the model; no comparisons here
   task automatic step(input logic ev, input logic [PA_W-1:0] pa,
                       input logic [DATA_W-1:0] d, input logic [1:0] sz,
                       input logic ack);
      bit   do_deq;
      bit   do_enq;
      st_t  e;
      enq_v    = ev;
      enq_pa   = pa;
      enq_data = d;
      enq_size = sz;
      mem_ack  = ack;
      do_deq   = (q.size() != 0) && ack;
      do_enq   = ev && (q.size() < DEPTH);
      @(posedge clk);
      if (do_deq) void'(q.pop_front());
      if (do_enq) begin
         e.pa = pa; e.data = d; e.size = sz;
         q.push_back(e);
      end
      #1;
      enq_v   = 1'b0;
      mem_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      ld_v = 1'b1; ld_pa = '0; ld_size = 2'b00;
      #1;
      n_tests++;
      if ({full, empty, count, mem_req, ld_hit} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_flags: got full=%b empty=%b count=%0d req=%b hit=%b want 0 1 0 0 0",
                  full, empty, count, mem_req, ld_hit);
      end
      n_tests++;
      if ({mem_pa, mem_data, mem_size} !== '0) begin
         n_fail++;
         $display("FAIL reset_payload: got pa=%h data=%h size=%b want zeros",
                  mem_pa, mem_data, mem_size);
      end
      ld_v = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      step(1'b1, 15'h0010, 32'hDEADBEEF, 2'b00, 1'b0);
      n_tests++;
      if ({mem_req, mem_pa, mem_data, mem_size, count} !==
          {1'b1, 15'h0010, 32'hDEADBEEF, 2'b00, 3'd1}) begin
         n_fail++;
         $display("FAIL basic_latency: got req=%b pa=%h data=%h size=%b count=%0d want 1 0010 deadbeef 00 1",
                  mem_req, mem_pa, mem_data, mem_size, count);
      end
      step(1'b0, '0, '0, 2'b00, 1'b1);
      n_tests++;
      if (empty !== 1'b1 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_drain: got empty=%b req=%b want 1 0", empty, mem_req);
      end
   endtask

   task automatic test_full();
      logic [PA_W-1:0] exp_pa;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         step(1'b1, PA_W'((k + 1) * 16), DATA_W'(k + 100), 2'b00, 1'b0);
         if (k == 3) begin
            n_tests++;
            if (full !== 1'b1) begin
               n_fail++;
               $display("FAIL full_after4: got full=%b want 1", full);
            end
         end
      end
      n_tests++;
      if (count !== 3'd4 || full !== 1'b1) begin
         n_fail++;
         $display("FAIL full_drop5: got count=%0d full=%b want 4 1", count, full);
      end
      for (int k = 0; k < 4; k++) begin
         exp_pa = PA_W'((k + 1) * 16);
         n_tests++;
         if (mem_pa !== exp_pa || mem_data !== DATA_W'(k + 100)) begin
            n_fail++;
            $display("FAIL full_order%0d: got pa=%h data=%h want pa=%h data=%h",
                     k, mem_pa, mem_data, exp_pa, k + 100);
         end
         step(1'b0, '0, '0, 2'b00, 1'b1);
      end
      n_tests++;
      if (empty !== 1'b1) begin
         n_fail++;
         $display("FAIL full_empty_after_drain: got empty=%b want 1", empty);
      end
   endtask

   task automatic test_full_deq();
      logic [PA_W-1:0] order [4];
      do_reset();
      for (int k = 0; k < 4; k++)
         step(1'b1, PA_W'(16'h100 + k * 4), DATA_W'(k), 2'b00, 1'b0);
      step(1'b1, 15'h0200, 32'h55, 2'b00, 1'b1);
      n_tests++;
      if (count !== 3'd3 || mem_pa !== 15'h0104) begin
         n_fail++;
         $display("FAIL fulldeq_no_take: got count=%0d pa=%h want 3 0104", count, mem_pa);
      end
      step(1'b1, 15'h0204, 32'h66, 2'b00, 1'b0);
      n_tests++;
      if (count !== 3'd4 || full !== 1'b1) begin
         n_fail++;
         $display("FAIL fulldeq_refill: got count=%0d full=%b want 4 1", count, full);
      end
      order[0] = 15'h0104; order[1] = 15'h0108;
      order[2] = 15'h010C; order[3] = 15'h0204;
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (mem_pa !== order[k]) begin
            n_fail++;
            $display("FAIL fulldeq_wrap%0d: got pa=%h want %h", k, mem_pa, order[k]);
         end
         step(1'b0, '0, '0, 2'b00, 1'b1);
      end
   endtask

   task automatic test_overlap();
      do_reset();
      step(1'b1, 15'h0006, 32'h1234, 2'b11, 1'b0);
      ld_v = 1'b1; ld_pa = 15'h0008; ld_size = 2'b01;
      #1;
      n_tests++;
      if (ld_hit !== 1'b1) begin
         n_fail++;
         $display("FAIL overlap_hit: got ld_hit=%b want 1", ld_hit);
      end
      ld_pa = 15'h000C;
      #1;
      n_tests++;
      if (ld_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL overlap_miss: got ld_hit=%b want 0", ld_hit);
      end
      ld_pa = 15'h0004; ld_size = 2'b00; mem_ack = 1'b1;
      #1;
      n_tests++;
      if (ld_hit !== 1'b1) begin
         n_fail++;
         $display("FAIL overlap_deq_same_cycle: got ld_hit=%b want 1", ld_hit);
      end
      ld_v = 1'b0;
      #1;
      n_tests++;
      if (ld_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL overlap_ldv_low: got ld_hit=%b want 0", ld_hit);
      end
      step(1'b0, '0, '0, 2'b00, 1'b1);
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int k = 0; k < 3; k++)
         step(1'b1, PA_W'(16'h40 + k * 4), DATA_W'(32'hA0 + k), 2'b10, 1'b0);
      n_tests++;
      if (count !== 3'd3 || mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_pre: got count=%0d req=%b want 3 1", count, mem_req);
      end
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if ({count, mem_req, full, empty, mem_pa, mem_data, mem_size} !==
          {3'd0, 1'b0, 1'b0, 1'b1, 15'h0, 32'h0, 2'b00}) begin
         n_fail++;
         $display("FAIL areset_async: got count=%0d req=%b empty=%b pa=%h data=%h want 0 0 1 0 0",
                  count, mem_req, empty, mem_pa, mem_data);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      step(1'b0, '0, '0, 2'b00, 1'b1);
      n_tests++;
      if (count !== 3'd0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_ack_ignored: got count=%0d empty=%b want 0 1", count, empty);
      end
   endtask

   task automatic test_stream();
      logic [PA_W-1:0]   pa;
      logic [DATA_W-1:0] d;
      do_reset();
      for (int k = 0; k < 20; k++) begin
         pa = PA_W'($urandom);
         d  = $urandom;
         step(1'b1, pa, d, 2'($urandom), 1'b1);
         n_tests++;
         if (count !== 3'd1 || mem_pa !== pa || mem_data !== d) begin
            n_fail++;
            $display("FAIL stream%0d: got count=%0d pa=%h data=%h want 1 %h %h",
                     k, count, mem_pa, mem_data, pa, d);
         end
      end
   endtask

   task automatic test_random();
      bit exp_hit;
      do_reset();
      for (int k = 0; k < 300; k++) begin
         ld_v    = ($urandom_range(0, 3) != 0);
         ld_pa   = PA_W'($urandom_range(0, 63));
         ld_size = 2'($urandom);
         #1;
         exp_hit = model_hit();
         n_tests++;
         if (ld_hit !== exp_hit) begin
            n_fail++;
            $display("FAIL rand_hit%0d: got ld_hit=%b want %b", k, ld_hit, exp_hit);
         end
         step(($urandom_range(0, 9) < 7), PA_W'($urandom_range(0, 63)),
              $urandom, 2'($urandom), ($urandom_range(0, 1) == 1));
         n_tests++;
         if (int'(count) !== q.size() || full !== (q.size() == DEPTH) ||
             empty !== (q.size() == 0) || mem_req !== (q.size() != 0)) begin
            n_fail++;
            $display("FAIL rand_state%0d: got count=%0d full=%b empty=%b req=%b want count=%0d",
                     k, count, full, empty, mem_req, q.size());
         end
         if (q.size() != 0) begin
            n_tests++;
            if (mem_pa !== q[0].pa || mem_data !== q[0].data || mem_size !== q[0].size) begin
               n_fail++;
               $display("FAIL rand_head%0d: got %h/%h/%b want %h/%h/%b", k,
                        mem_pa, mem_data, mem_size, q[0].pa, q[0].data, q[0].size);
            end
         end
      end
      ld_v = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      enq_v    = 1'b0;
      enq_pa   = '0;
      enq_data = '0;
      enq_size = 2'b00;
      mem_ack  = 1'b0;
      ld_v     = 1'b0;
      ld_pa    = '0;
      ld_size  = 2'b00;
      #2;
      test_reset();
      test_basic();
      test_full();
      test_full_deq();
      test_overlap();
      test_async_reset();
      test_stream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
